// File: rtl/width_conv_sched.sv
// width_conv_sched: sequencer for the 256->324-bit DRM width converter.
// Issues one 81-beat read burst per group, gates returned beats into the
// converter, pulses a converter phase clear at job start, reserves downstream
// FIFO space per burst and signals completion after num_groups*64 words.
//
// Optional build macro: WIDTH_CONV_SCHED_PERF_EN adds the stall_cycles counter.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             job start pulse (accepted in IDLE only)
//   base_addr         byte address of the first beat
//   num_groups        groups in the job
//   busy, done        job in progress / one-cycle completion pulse
//   cmd_valid/ready   read command handshake
//   cmd_addr, cmd_len burst start address / burst length minus 1
//   rd_valid          returned beat strobe from memory
//   conv_valid_in     beat strobe to converter (combinational)
//   conv_clr          one-cycle converter phase clear
//   conv_valid_out    converter output word strobe
//   fifo_free         free words in downstream FIFO
//   err_overrun       sticky unexpected beat/word flag
//   stall_cycles      (perf build) cycles with work pending but no command
module width_conv_sched #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned BEAT_BYTES      = 32,
    parameter int unsigned GROUP_BEATS     = 81,
    parameter int unsigned GROUP_WORDS     = 64,
    parameter int unsigned GRP_WIDTH       = 16,
    parameter int unsigned FREE_WIDTH      = 10,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [GRP_WIDTH-1:0]  num_groups,
    output logic                  busy,
    output logic                  done,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [7:0]            cmd_len,
    input  logic                  rd_valid,
    output logic                  conv_valid_in,
    output logic                  conv_clr,
    input  logic                  conv_valid_out,
    input  logic [FREE_WIDTH-1:0] fifo_free,
    output logic                  err_overrun
`ifdef WIDTH_CONV_SCHED_PERF_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int unsigned BEAT_W = $clog2(GROUP_BEATS);
    localparam int unsigned OUT_W  = 2;
    localparam int unsigned RES_W  = FREE_WIDTH + 1;
    localparam int unsigned CMP_W  = RES_W + 1;
    localparam int unsigned WORD_W = GRP_WIDTH + 7;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(GROUP_BEATS * BEAT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t                state_q, state_d;
    logic [GRP_WIDTH-1:0]  ng_q, ng_d;
    logic [GRP_WIDTH-1:0]  issued_q, issued_d;
    logic [OUT_W-1:0]      outst_q, outst_d;
    logic [RES_W-1:0]      reserved_q, reserved_d;
    logic [WORD_W-1:0]     words_q, words_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  err_d;
    logic                  cmd_valid_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  clr_d;

    logic                  cmd_accept;
    logic                  grp_done;
    logic                  word_ok;
    logic                  beat_orphan;
    logic                  word_extra;
    logic [WORD_W-1:0]     total;

    // Beats pass to the converter only while a burst is in flight.
    assign conv_valid_in = rd_valid & (outst_q != '0);
    assign cmd_len       = 8'(GROUP_BEATS - 1);

    assign total       = WORD_W'(ng_q) * WORD_W'(GROUP_WORDS);
    assign cmd_accept  = cmd_valid & cmd_ready;
    assign grp_done    = conv_valid_in & (beat_q == BEAT_W'(GROUP_BEATS - 1));
    assign word_ok     = conv_valid_out & (words_q != total);
    assign beat_orphan = rd_valid & (outst_q == '0);
    assign word_extra  = conv_valid_out & (words_q == total);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter updates and next values of registered outputs.
    always_comb begin
        state_d     = state_q;
        ng_d        = ng_q;
        addr_d      = cmd_addr;
        issued_d    = issued_q;
        outst_d     = outst_q;
        reserved_d  = reserved_q;
        words_d     = words_q;
        beat_d      = beat_q;
        err_d       = err_overrun;
        cmd_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        clr_d       = 1'b0;

        if (cmd_accept) begin
            issued_d = issued_q + GRP_WIDTH'(1);
            addr_d   = cmd_addr + ADDR_STEP;
        end
        if (conv_valid_in) begin
            beat_d = grp_done ? '0 : beat_q + BEAT_W'(1);
        end
        // Accept and group completion in the same cycle cancel out.
        case ({cmd_accept, grp_done})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase
        // Reservation grows by a group on accept and shrinks per emitted word.
        reserved_d = reserved_q + (cmd_accept ? RES_W'(GROUP_WORDS) : RES_W'(0));
        if (word_ok) begin
            words_d = words_q + WORD_W'(1);
            if (reserved_d != '0) begin
                reserved_d = reserved_d - RES_W'(1);
            end
        end
        if (beat_orphan || word_extra) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CLR;
                    ng_d       = num_groups;
                    addr_d     = base_addr;
                    issued_d   = '0;
                    outst_d    = '0;
                    reserved_d = '0;
                    words_d    = '0;
                    beat_d     = '0;
                    err_d      = 1'b0;
                end
            end
            S_CLR:   state_d = (ng_q == '0) ? S_FIN : S_RUN;
            S_RUN: begin
                if (issued_q == ng_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((words_q == total) && (outst_q == '0)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A raised command is held until accepted; a new one is raised from
        // post-update counters so an accept never double-issues.
        cmd_valid_d = (cmd_valid && !cmd_ready) ||
                      ((state_d == S_RUN) && (issued_d < ng_q) &&
                       (outst_d < OUT_W'(MAX_OUTSTANDING)) &&
                       (CMP_W'(fifo_free) >= (CMP_W'(reserved_d) + CMP_W'(GROUP_WORDS))));

        busy_d = (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_FIN);
        clr_d  = (state_d == S_CLR);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ng_q        <= '0;
            issued_q    <= '0;
            outst_q     <= '0;
            reserved_q  <= '0;
            words_q     <= '0;
            beat_q      <= '0;
            cmd_addr    <= '0;
            cmd_valid   <= 1'b0;
            err_overrun <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            conv_clr    <= 1'b0;
        end else begin
            ng_q        <= ng_d;
            issued_q    <= issued_d;
            outst_q     <= outst_d;
            reserved_q  <= reserved_d;
            words_q     <= words_d;
            beat_q      <= beat_d;
            cmd_addr    <= addr_d;
            cmd_valid   <= cmd_valid_d;
            err_overrun <= err_d;
            busy        <= busy_d;
            done        <= done_d;
            conv_clr    <= clr_d;
        end
    end

`ifdef WIDTH_CONV_SCHED_PERF_EN
    logic [31:0] stall_d;

    // Count cycles where groups remain but no command is being offered.
    always_comb begin
        stall_d = stall_cycles;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if (((state_q == S_RUN) || (state_q == S_DRAIN)) && !cmd_valid &&
                     (issued_q < ng_q) && (stall_cycles != '1)) begin
            stall_d = stall_cycles + 32'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else begin
            stall_cycles <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_width_conv_sched.sv
// Testbench for width_conv_sched: randomized memory/converter environment,
// cumulative-count reference model, per-cycle compare plus literal checks.
module tb_width_conv_sched;

    localparam int GB   = 81;
    localparam int GW   = 64;
    localparam int STEP = 2592;
    localparam int MAXO = 2;

    logic        clk, rst, start;
    logic [31:0] base_addr;
    logic [15:0] num_groups;
    logic        busy, done, cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        rd_valid, conv_valid_in, conv_clr, conv_valid_out;
    logic [9:0]  fifo_free;
    logic        err_overrun;
`ifdef WIDTH_CONV_SCHED_PERF_EN
    logic [31:0] stall_cycles;
`endif

    width_conv_sched dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_groups(num_groups), .busy(busy), .done(done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .rd_valid(rd_valid), .conv_valid_in(conv_valid_in),
        .conv_clr(conv_clr), .conv_valid_out(conv_valid_out),
        .fifo_free(fifo_free), .err_overrun(err_overrun)
`ifdef WIDTH_CONV_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Environment knobs and bookkeeping.
    bit env_on = 0;
    bit free_rand = 0;
    bit start_req = 0;
    int p_ready = 100, p_rd = 100, p_word = 100;
    int ready_delay = 0, word_cap = 1 << 30, free_val = 1023;
    int mem_pend = 0, delivered = 0, emitted = 0, wait_cnt = 0;

    // Observed-event monitors.
    int n_acc = 0, n_clr = 0, n_fwd = 0, n_done = 0, n_cv = 0;
    logic [31:0] acc_addr[$];

    // Reference model: cumulative job counts; derived quantities from them.
    int          m_phase = 0;    // 0 idle, 1 clr, 2 run, 3 drain, 4 fin
    int          m_ng = 0, m_iss = 0, m_beats = 0, m_words = 0;
    logic [31:0] m_base = 0;
    bit          m_err = 0, m_cv = 0;
    logic [31:0] m_stall = 0;
    int          o_old, tot, nph, o_new, r_new;
    bit          fwd, acc, wok, ev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_ng = 0; m_iss = 0; m_beats = 0; m_words = 0;
            m_base = 0; m_err = 0; m_cv = 0; m_stall = 0;
        end else begin
            o_old = m_iss - m_beats / GB;
            tot   = m_ng * GW;
            fwd   = rd_valid && (o_old > 0);
            acc   = m_cv && cmd_ready;
            wok   = conv_valid_out && (m_words != tot);
            ev    = (rd_valid && o_old == 0) || (conv_valid_out && !wok);

            if (cmd_valid && cmd_ready) begin
                n_acc++;
                acc_addr.push_back(cmd_addr);
            end
            if (conv_clr) n_clr++;
            if (conv_valid_in) n_fwd++;
            if (done) n_done++;
            if (cmd_valid) n_cv++;

            if ((m_phase == 2 || m_phase == 3) && !m_cv && m_iss < m_ng && m_stall != 32'hFFFF_FFFF)
                m_stall = m_stall + 1;

            nph = m_phase;
            case (m_phase)
                0: if (start) nph = 1;
                1: nph = (m_ng == 0) ? 4 : 2;
                2: if (m_iss == m_ng) nph = 3;
                3: if (m_words == tot && o_old == 0) nph = 4;
                default: nph = 0;
            endcase

            if (m_phase == 0 && start) begin
                m_ng = int'(num_groups); m_base = base_addr;
                m_iss = 0; m_beats = 0; m_words = 0; m_err = 0; m_stall = 0;
            end else begin
                m_iss   += int'(acc);
                m_beats += int'(fwd);
                m_words += int'(wok);
                if (ev) m_err = 1;
            end
            m_phase = nph;

            o_new = m_iss - m_beats / GB;
            r_new = m_iss * GW - m_words;
            m_cv  = (m_cv && !cmd_ready) ||
                    (m_phase == 2 && m_iss < m_ng && o_new < MAXO && int'(fifo_free) >= r_new + GW);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("busy", busy, (m_phase >= 1 && m_phase <= 3));
        chk("done", done, m_phase == 4);
        chk("conv_clr", conv_clr, m_phase == 1);
        chk("cmd_valid", cmd_valid, m_cv);
        chk("cmd_addr", cmd_addr, m_base + 32'(m_iss * STEP));
        chk("cmd_len", cmd_len, 80);
        chk("conv_valid_in", conv_valid_in, rd_valid && (m_iss - m_beats / GB) > 0);
        chk("err_overrun", err_overrun, m_err);
`ifdef WIDTH_CONV_SCHED_PERF_EN
        chk("stall_cycles", stall_cycles, m_stall);
`endif
    end

    task automatic env_drive();
        int avail;
        if (!env_on) return;
        avail = delivered * GW / GB - emitted;
        conv_valid_out = (avail > 0) && (emitted < word_cap) && (int'($urandom_range(99)) < p_word);
        if (conv_valid_out) emitted++;
        rd_valid = (mem_pend > 0) && (int'($urandom_range(99)) < p_rd);
        if (rd_valid) begin
            mem_pend--;
            delivered++;
        end
        if (cmd_valid) begin
            cmd_ready = (wait_cnt >= ready_delay) && (int'($urandom_range(99)) < p_ready);
            wait_cnt++;
        end else begin
            cmd_ready = int'($urandom_range(99)) < p_ready;
            wait_cnt = 0;
        end
        if (cmd_valid && cmd_ready) begin
            mem_pend += GB;
            wait_cnt = 0;
        end
        fifo_free = free_rand ? 10'($urandom_range(64, 1023)) : 10'(free_val);
    endtask

    task automatic cycle();
        @(negedge clk);
        #1;
        start = start_req;
        start_req = 0;
        env_drive();
    endtask

    task automatic env_reset();
        mem_pend = 0; delivered = 0; emitted = 0; wait_cnt = 0;
        rd_valid = 0; conv_valid_out = 0; cmd_ready = 0;
        n_acc = 0; n_clr = 0; n_fwd = 0; n_done = 0; n_cv = 0;
        acc_addr.delete();
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            if (done) seen = 1;
        end
        chk("job_done_timeout", seen, 1);
    endtask

    task automatic run_job(input int ng, input logic [31:0] base, input int budget);
        env_reset();
        num_groups = 16'(ng);
        base_addr  = base;
        start_req  = 1;
        cycle();
        wait_done(budget);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] a[3];
        bit          hit;
        int          ng;

        rst = 1; start = 0; base_addr = 0; num_groups = 0;
        cmd_ready = 0; rd_valid = 0; conv_valid_out = 0; fifo_free = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_err", err_overrun, 0);
        chk("rst_clr", conv_clr, 0);
        #1 rst = 0;

        // Full-rate three-group job.
        env_on = 1; p_ready = 100; p_rd = 100; p_word = 100; free_val = 1023;
        run_job(3, 32'h1000, 2000);
        chk("t1_cmds", n_acc, 3);
        for (int i = 0; i < 3; i++) a[i] = (acc_addr.size() > i) ? acc_addr[i] : 32'hDEAD_BEEF;
        chk("t1_addr0", a[0], 32'h1000);
        chk("t1_addr1", a[1], 32'h1A20);
        chk("t1_addr2", a[2], 32'h2440);
        chk("t1_clr_pulses", n_clr, 1);
        chk("t1_beats_fwd", n_fwd, 243);
        chk("t1_words", emitted, 192);
        chk("t1_model_iss", m_iss, 3);
        chk("t1_model_beats", m_beats, 243);
        cycle();

        // Downstream space throttles the second burst.
        env_reset();
        free_val = 100; word_cap = 10;
        num_groups = 2; base_addr = 32'h8000; start_req = 1;
        cycle();
        for (int i = 0; i < 300 && emitted < 10; i++) cycle();
        repeat (20) cycle();
        chk("t2_one_cmd", n_acc, 1);
        free_val = 200; word_cap = 1 << 30;
        wait_done(2000);
        chk("t2_two_cmds", n_acc, 2);
        free_val = 1023;
        cycle();

        // Zero-group job.
        env_reset();
        num_groups = 0; start_req = 1;
        cycle();
        cycle();
        chk("t3_clr", conv_clr, 1);
        chk("t3_busy", busy, 1);
        cycle();
        chk("t3_done", done, 1);
        chk("t3_busy_fin", busy, 0);
        chk("t3_no_cmd", n_cv, 0);
        cycle();

        // Orphan beat and extra word raise the sticky error.
        env_on = 0;
        env_reset();
        cycle();
        rd_valid = 1;
        #1 chk("t4_gated", conv_valid_in, 0);
        cycle();
        rd_valid = 0;
        cycle();
        chk("t4_err_set", err_overrun, 1);
        num_groups = 0; start_req = 1;
        cycle();
        cycle();
        chk("t4_err_clr", err_overrun, 0);
        repeat (2) cycle();
        conv_valid_out = 1;
        cycle();
        conv_valid_out = 0;
        cycle();
        chk("t4_word_err", err_overrun, 1);

        // Asynchronous reset mid-burst, then a clean job.
        env_on = 1;
        env_reset();
        num_groups = 2; base_addr = 32'h0; start_req = 1;
        cycle();
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            cycle();
            if (delivered >= GB + 41) hit = 1;
        end
        chk("t5_reach_beat40", hit, 1);
        rst = 1;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_cmd_valid", cmd_valid, 0);
        chk("t5_fwd", conv_valid_in, 0);
        env_reset();
        cycle();
        cycle();
        rst = 0;
        run_job(2, 32'h0, 3000);
        chk("t5_cmds", n_acc, 2);
        chk("t5_beats", n_fwd, 162);
        cycle();

        // Randomized jobs with random handshakes and FIFO space.
        free_rand = 1;
        for (int k = 0; k < 5; k++) begin
            p_ready = $urandom_range(30, 100);
            p_rd    = $urandom_range(30, 100);
            p_word  = $urandom_range(30, 100);
            ng      = $urandom_range(1, 4);
            run_job(ng, $urandom, 8000);
            chk("rand_words", emitted, ng * GW);
            chk("rand_beats", n_fwd, ng * GB);
            repeat ($urandom_range(1, 4)) cycle();
        end
        free_rand = 0; p_ready = 100; p_rd = 100; p_word = 100;

`ifdef WIDTH_CONV_SCHED_PERF_EN
        // Held commands do not count as stalls; FIFO-blocked cycles do.
        ready_delay = 5; free_val = 1023;
        run_job(2, 32'h4000, 2000);
        chk("p_cmds", n_acc, 2);
        chk("p_no_stall", stall_cycles, 0);
        ready_delay = 0;
        cycle();
        env_reset();
        free_val = 0;
        num_groups = 1; start_req = 1;
        cycle();
        repeat (7) cycle();
        free_val = 1023;
        wait_done(2000);
        chk("p_stall7", stall_cycles, 7);
        repeat (3) cycle();
        chk("p_stall_held", stall_cycles, 7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
